// File: rtl/tick_gen_prog.sv
// ============================================================================
// tick_gen_prog : programmable tick generator producing a one-cycle strobe
// and an optional square wave, with pause/clear and period-boundary reload.
// Optional oTickCnt tick counter enabled by macro TICK_GEN_PROG_TCNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_gen_prog #(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iClr,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iDiv,
  input  logic             iMode,
  output logic             oTick,
  output logic             oSq,
  output logic             oPend,
  output logic [WIDTH-1:0] oCount
`ifdef TICK_GEN_PROG_TCNT_EN
  ,
  output logic [15:0]      oTickCnt
`endif
);

  localparam logic [WIDTH-1:0] C_DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic [WIDTH-1:0] w_last;
  logic             w_term;

  // Divisor 0 is treated as 1, so the terminal count is 0 in both cases.
  assign w_last = (div_q == '0) ? '0 : div_q - WIDTH'(1);
  assign w_term = iEn && !iClr && (cnt_q == w_last);

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    sq_d       = sq_q;

    if (iClr) begin
      cnt_d = '0;
    end else if (iEn) begin
      if (w_term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end

    if (!iMode) begin
      sq_d = 1'b0;
    end else if (w_term) begin
      sq_d = ~sq_q;
    end

    // A load landing on the boundary bypasses the pending register.
    if (w_term) begin
      if (iLoad) begin
        div_d  = iDiv;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = pend_val_q;
        pend_d = 1'b0;
      end
    end else if (iLoad) begin
      pend_val_d = iDiv;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt_q      <= '0;
      div_q      <= C_DIV_RST;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      sq_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
    end
  end

  assign oTick  = tick_q;
  assign oSq    = sq_q;
  assign oPend  = pend_q;
  assign oCount = cnt_q;

`ifdef TICK_GEN_PROG_TCNT_EN
  logic [15:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    if (iClr) begin
      tcnt_d = '0;
    end else if (w_term) begin
      tcnt_d = tcnt_q + 16'd1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign oTickCnt = tcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tick_gen_prog.sv
// Scoreboard bench for tick_gen_prog: a behavioural model queues the expected
// outputs for every edge, a monitor pops and compares them each cycle.
`default_nettype none

module tb_tick_gen_prog;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0, clr = 1'b0, load = 1'b0, mode = 1'b0;
  logic [WIDTH-1:0] div = '0;
  logic             tick, sq, pend;
  logic [WIDTH-1:0] count;
  logic [15:0]      tcnt;

  always #5 clk = ~clk;

  tick_gen_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .iClk(clk), .iRst(rst), .iEn(en), .iClr(clr), .iLoad(load),
    .iDiv(div), .iMode(mode), .oTick(tick), .oSq(sq), .oPend(pend),
    .oCount(count)
`ifdef TICK_GEN_PROG_TCNT_EN
    , .oTickCnt(tcnt)
`endif
  );

`ifndef TICK_GEN_PROG_TCNT_EN
  assign tcnt = 16'd0;
`endif

  typedef struct {
    int tick; int sq; int pend; int cnt; int tc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: period-phase view of the divider
  int m_phase, m_period_reg, m_pend_val, m_tc;
  bit m_pend, m_sq;

  function automatic void model_reset();
    m_phase = 0; m_period_reg = DEFAULT_DIV; m_pend_val = 0;
    m_pend = 0; m_sq = 0; m_tc = 0;
  endfunction

  function automatic exp_t model_step(bit e, bit c, bit l, int d, bit md);
    exp_t r;
    int   period;
    bit   boundary;
    period   = (m_period_reg == 0) ? 1 : m_period_reg;
    boundary = e && !c && (m_phase + 1 == period);
    if (c)      m_phase = 0;
    else if (e) m_phase = (m_phase + 1) % period;
    m_sq = md ? (m_sq ^ boundary) : 1'b0;
    if (c)             m_tc = 0;
    else if (boundary) m_tc = (m_tc + 1) % 65536;
    if (boundary) begin
      if (l)           m_period_reg = d;
      else if (m_pend) m_period_reg = m_pend_val;
      m_pend = 0;
    end else if (l) begin
      m_pend_val = d;
      m_pend     = 1;
    end
    r.tick = boundary; r.sq = m_sq; r.pend = m_pend; r.cnt = m_phase; r.tc = m_tc;
    return r;
  endfunction

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("tick",  int'(tick),  e.tick);
      check("sq",    int'(sq),    e.sq);
      check("pend",  int'(pend),  e.pend);
      check("count", int'(count), e.cnt);
`ifdef TICK_GEN_PROG_TCNT_EN
      check("tickcnt", int'(tcnt), e.tc);
`endif
    end
  end

  // Called at negedge+1: applies inputs for the coming edge, queues expectation
  task automatic cyc(bit e, bit c, bit l, int d, bit md);
    en = e; clr = c; load = l; div = WIDTH'(d); mode = md;
    exp_q.push_back(model_step(e, c, l, d, md));
    @(negedge clk); #1;
  endtask

  task automatic run(int n, bit md);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, md);
  endtask

  // Asserts reset between edges and checks the outputs drop without a clock
  task automatic do_reset();
    rst = 1'b1;
    en = 0; clr = 0; load = 0; mode = 0;
    #1;
    check("rst_tick",  int'(tick),  0);
    check("rst_sq",    int'(sq),    0);
    check("rst_pend",  int'(pend),  0);
    check("rst_count", int'(count), 0);
    check("rst_tcnt",  int'(tcnt),  0);
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk); #1;
    do_reset();
    // Default period, square disabled then enabled
    run(35, 0);
    do_reset();
    run(45, 1);
    // Load 4 mid-period, then a load coincident with the terminal edge
    do_reset();
    run(12, 0); cyc(1, 0, 1, 4, 0); run(22, 0);
    do_reset();
    run(19, 0); cyc(1, 0, 1, 4, 0); run(12, 0);
    // Pause at count 6 for 5 cycles
    do_reset();
    run(6, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    run(16, 0);
    // Divisor 0 then 1: continuous tick, square toggles every cycle
    do_reset();
    cyc(1, 0, 1, 0, 1); run(12, 1); run(4, 1);
    cyc(1, 0, 1, 1, 1); run(6, 1);
    cyc(0, 0, 0, 0, 1); run(4, 1);
    // Async reset with a pending load and count 7
    do_reset();
    run(3, 0); cyc(1, 0, 1, 3, 0); run(3, 0);
    check("pre_rst_count", int'(count), 7);
    check("pre_rst_pend",  int'(pend),  1);
    do_reset();
    run(22, 0);
    // Randomised traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      bit e, c, l, md;
      int d;
      e  = ($urandom_range(0, 9) < 8);
      c  = ($urandom_range(0, 29) == 0);
      l  = ($urandom_range(0, 14) == 0);
      d  = (($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7));
      md = (i % 100) >= 30;
      cyc(e, c, l, d, md);
      if (i == 250) do_reset();
    end
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
